imem_load_controller: RTL and testbench
=======================================

// Module: imem_load_controller
// PURPOSE
//  Sequences the instruction memory: loads a program byte-stream (UART RX) into it, then hands the
//  read port to the CPU fetch stage. Owns the memory's address/write port; gates CPU execution.
//  Sits between UART RX, PC register and instruction memory; 4 bytes assembled MSB-first per word.
// PARAMETERS
//  NBITS      32    instruction/data word width and PC width
//  CELDAS     60    memory depth in byte-address units; words stored at addresses 0,4,8,...
//  HALT_WORD  32'hFFFF_FFFF  end-of-program marker (also written to memory)
// PORTS
//  i_clk          in   1      clock, all logic posedge
//  i_reset_n      in   1      asynchronous active-low reset
//  i_load_req     in   1      level/pulse: (re)start program load, sampled in IDLE and RUN
//  i_rx_data      in   8      received byte
//  i_rx_valid     in   1      1-cycle strobe, i_rx_data valid
//  i_PC           in   NBITS  fetch address from PC
//  o_mem_addr     out  NBITS  address to instruction memory (load addr or i_PC)
//  o_mem_wdata    out  NBITS  assembled word
//  o_mem_we       out  1      write strobe, 1 cycle per word
//  o_cpu_en       out  1      CPU/PC enable; 1 only in RUN
//  o_load_done    out  1      1 from program completion until next load starts
//  o_load_err     out  1      checksum error / overrun sticky flag, cleared on load start
//  o_word_count   out  NBITS  words written this load
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, all outputs 0, load address=0, byte count=0.
//  States: IDLE, LOAD, WRITE, RUN (+CHECK, ERROR with macro).
//  IDLE: i_load_req -> LOAD; clears addr, byte cnt, word cnt, done, err.
//  LOAD: each i_rx_valid shifts byte in: word <= {word[23:0],byte}; cnt++; 4th byte -> WRITE next cycle.
//  WRITE: o_mem_we=1 exactly this cycle, o_mem_addr=load addr, o_mem_wdata=word; o_word_count++.
//   next: word==HALT_WORD or addr+4>=CELDAS -> RUN (or CHECK); else addr+=4 -> LOAD.
//  Capacity end (addr+4>=CELDAS) without HALT: treated as implicit halt, no error.
//  i_rx_valid in WRITE/RUN/IDLE: byte dropped; in WRITE additionally sets o_load_err (overrun).
//  RUN: o_cpu_en=1, o_load_done=1, o_mem_addr=i_PC combinationally, o_mem_we=0.
//  i_load_req in RUN -> LOAD next cycle, o_cpu_en drops same edge, counters cleared (full reload).
//  i_load_req in LOAD/WRITE: ignored. Latency: 4th byte strobe -> write 1 cycle later.
//  Outside RUN o_mem_addr = load addr; o_cpu_en=0 (PC must hold).
//  Reset mid-load: all progress lost, memory contents untouched, returns to IDLE.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: after HALT/capacity write, enter CHECK; next byte compared
//   with XOR of all program bytes (incl. HALT). Match -> RUN. Mismatch -> ERROR: o_load_err=1,
//   o_cpu_en=0, o_load_done=0; only i_load_req leaves ERROR (-> LOAD).
//  Not defined: no CHECK/ERROR states, no XOR accumulator; o_load_err reports overrun only.
// STRUCTURE
//  Package imem_loader_pkg: state enum, HALT_WORD, BYTES_PER_WORD=4, ADDR_STEP=4.
//  Sub-module imem_byte_assembler: 8->32 shift register, 2-bit byte counter, word_ready pulse,
//   clear input; controller FSM, address/word counters, port mux stay in top.
// TESTING
//  1 reset, load_req, bytes 00 00 08 20 | FF FF FF FF -> we@addr0 data 0000_0820, we@addr4 FFFF_FFFF,
//    o_word_count=2, then o_cpu_en=1, o_load_done=1, o_mem_addr follows i_PC=0x10.
//  2 15 non-HALT words with CELDAS=60 -> last write at addr 56, RUN entered, o_load_err=0.
//  3 byte strobe on the WRITE cycle -> byte dropped, o_load_err=1, next word assembled from following 4.
//  4 RUN with i_PC=8, assert i_load_req -> o_cpu_en=0 next edge, addr restarts 0, count=0, done=0.
//  5 i_reset_n low after 2 bytes -> outputs 0 immediately (async); reload from scratch writes addr 0.
//  6 (CHECKSUM_EN) program 00000820,FFFFFFFF + byte 0x28 -> RUN; byte 0x29 -> ERROR, err=1, cpu_en=0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared constants for the instruction-memory load controller:
//   - FSM state encoding (legacy-compatible 3-bit constants)
//   - default end-of-program marker, bytes per word, address step
//   - byte-wise XOR accumulate helper used by the optional checksum
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (CHECK/ERROR states).
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int ADDR_STEP      = 4;

    localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFFFF_FFFF;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_WRITE = 3'd2;
    localparam state_t ST_RUN   = 3'd3;
    localparam state_t ST_CHECK = 3'd4;
    localparam state_t ST_ERROR = 3'd5;

    // Running XOR checksum: fold one more program byte into the accumulator.
    function automatic logic [7:0] xor_accumulate(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/imem_load_controller_if.sv
// -----------------------------------------------------------------------------
// imem_load_controller_if
// Bus bundle between the load controller, the UART RX byte stream, the PC and
// the instruction memory port.
//   rx_data   [7:0]   received byte
//   rx_valid          1-cycle strobe, rx_data valid
//   pc        [N-1:0] fetch address from the PC register
//   mem_addr  [N-1:0] address to instruction memory
//   mem_wdata [N-1:0] word to write
//   mem_we            write strobe
// Modports: slave = controller side, master = environment side.
// -----------------------------------------------------------------------------
interface imem_load_controller_if #(
    parameter int NBITS = 32
);
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic [NBITS-1:0] pc;
    logic [NBITS-1:0] mem_addr;
    logic [NBITS-1:0] mem_wdata;
    logic             mem_we;

    modport master (
        output rx_data, rx_valid, pc,
        input  mem_addr, mem_wdata, mem_we
    );

    modport slave (
        input  rx_data, rx_valid, pc,
        output mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/imem_byte_assembler.sv
// -----------------------------------------------------------------------------
// imem_byte_assembler
// Packs a byte stream MSB-first into NBITS-wide words.
//   i_clk, i_reset_n  clock / async active-low reset
//   i_clear           drop any partial word (load restart)
//   i_byte_valid      shift i_byte in this cycle
//   i_byte [7:0]      incoming byte
//   o_word            current shift-register contents
//   o_word_ready      combinational: this strobe completes a word, so the
//                     word is complete on the next cycle
// -----------------------------------------------------------------------------
module imem_byte_assembler
    import imem_loader_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_clear,
    input  logic             i_byte_valid,
    input  logic [7:0]       i_byte,
    output logic [NBITS-1:0] o_word,
    output logic             o_word_ready
);

    logic [NBITS-1:0] word_r;
    logic [1:0]       byte_cnt_r;

    // Shift register and byte counter; counter wraps to 0 after the last byte.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            word_r     <= '0;
            byte_cnt_r <= 2'd0;
        end else if (i_clear) begin
            word_r     <= '0;
            byte_cnt_r <= 2'd0;
        end else if (i_byte_valid) begin
            word_r     <= {word_r[NBITS-9:0], i_byte};
            byte_cnt_r <= byte_cnt_r + 2'd1;
        end else begin
            word_r     <= word_r;
            byte_cnt_r <= byte_cnt_r;
        end
    end

    // Combinational so the controller can enter WRITE one cycle after the last strobe.
    assign o_word_ready = i_byte_valid && !i_clear &&
                          (byte_cnt_r == 2'(BYTES_PER_WORD - 1));
    assign o_word       = word_r;

endmodule

// File: rtl/imem_load_controller.sv
// -----------------------------------------------------------------------------
// imem_load_controller
// Loads a program byte stream into instruction memory (4 bytes per word,
// MSB first, words at 0,4,8,...), then hands the memory read port to the CPU.
// Ports:
//   i_clk, i_reset_n   clock / async active-low reset
//   i_load_req         (re)start program load, honoured in IDLE and RUN
//   bus (slave)        rx byte stream, PC, memory address/data/write strobe
//   o_cpu_en           CPU/PC enable, high only in RUN
//   o_load_done        high from program completion until the next load starts
//   o_load_err         sticky overrun (and checksum) error, cleared on load start
//   o_word_count       words written during the current load
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- after the last word, one
// extra byte must equal the XOR of all program bytes; mismatch parks the
// controller in ERROR until the next load request.
// -----------------------------------------------------------------------------
module imem_load_controller
    import imem_loader_pkg::*;
#(
    parameter int               NBITS     = 32,
    parameter int               CELDAS    = 60,
    parameter logic [NBITS-1:0] HALT_WORD = HALT_WORD_DEFAULT
) (
    input  logic                     i_clk,
    input  logic                     i_reset_n,
    input  logic                     i_load_req,
    imem_load_controller_if.slave    bus,
    output logic                     o_cpu_en,
    output logic                     o_load_done,
    output logic                     o_load_err,
    output logic [NBITS-1:0]         o_word_count
);

    state_t           state_r;
    state_t           next_state_s;
    logic [NBITS-1:0] load_addr_r;
    logic [NBITS-1:0] word_count_r;
    logic             cpu_en_r;
    logic             load_done_r;
    logic             load_err_r;
    logic             mem_we_r;
    logic             start_load_s;
    logic             last_word_s;
    logic             byte_in_s;
    logic             word_ready_s;
    logic [NBITS-1:0] word_s;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xsum_r;
    logic       sum_ok_s;
    assign sum_ok_s = (bus.rx_data == xsum_r);
`endif

    // Bytes are only accepted while loading; elsewhere they are dropped.
    assign byte_in_s = (state_r == ST_LOAD) && bus.rx_valid;

    // Program ends on the halt marker or when the next slot would be out of range.
    assign last_word_s = (word_s == HALT_WORD) ||
                         ((load_addr_r + NBITS'(ADDR_STEP)) >= NBITS'(CELDAS));

    imem_byte_assembler #(
        .NBITS (NBITS)
    ) u_assembler (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_clear      (start_load_s),
        .i_byte_valid (byte_in_s),
        .i_byte       (bus.rx_data),
        .o_word       (word_s),
        .o_word_ready (word_ready_s)
    );

    // Next-state logic; start_load_s flags every transition that begins a fresh load.
    always_comb begin
        next_state_s = state_r;
        start_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (i_load_req) begin
                    next_state_s = ST_LOAD;
                    start_load_s = 1'b1;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (word_ready_s) begin
                    next_state_s = ST_WRITE;
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_WRITE: begin
                if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    next_state_s = ST_CHECK;
`else
                    next_state_s = ST_RUN;
`endif
                end else begin
                    next_state_s = ST_LOAD;
                end
            end
            ST_RUN: begin
                if (i_load_req) begin
                    next_state_s = ST_LOAD;
                    start_load_s = 1'b1;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (bus.rx_valid) begin
                    next_state_s = sum_ok_s ? ST_RUN : ST_ERROR;
                end else begin
                    next_state_s = ST_CHECK;
                end
            end
            ST_ERROR: begin
                if (i_load_req) begin
                    next_state_s = ST_LOAD;
                    start_load_s = 1'b1;
                end else begin
                    next_state_s = ST_ERROR;
                end
            end
`endif
            default: begin
                next_state_s = ST_IDLE;
                start_load_s = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Status/strobe outputs registered from the next state so they align with it.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cpu_en_r    <= 1'b0;
            load_done_r <= 1'b0;
            mem_we_r    <= 1'b0;
        end else begin
            cpu_en_r    <= (next_state_s == ST_RUN);
            load_done_r <= (next_state_s == ST_RUN);
            mem_we_r    <= (next_state_s == ST_WRITE);
        end
    end

    // Load address and word counter; address stays on the final slot after the last word.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            load_addr_r  <= '0;
            word_count_r <= '0;
        end else if (start_load_s) begin
            load_addr_r  <= '0;
            word_count_r <= '0;
        end else if (state_r == ST_WRITE) begin
            word_count_r <= word_count_r + {{(NBITS-1){1'b0}}, 1'b1};
            if (!last_word_s) begin
                load_addr_r <= load_addr_r + NBITS'(ADDR_STEP);
            end else begin
                load_addr_r <= load_addr_r;
            end
        end else begin
            load_addr_r  <= load_addr_r;
            word_count_r <= word_count_r;
        end
    end

    // Sticky error: byte arriving while a word is being written, or a bad checksum.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            load_err_r <= 1'b0;
        end else if (start_load_s) begin
            load_err_r <= 1'b0;
        end else if ((state_r == ST_WRITE) && bus.rx_valid) begin
            load_err_r <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        end else if ((state_r == ST_CHECK) && (next_state_s == ST_ERROR)) begin
            load_err_r <= 1'b1;
`endif
        end else begin
            load_err_r <= load_err_r;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    // XOR of every accepted program byte, including the halt word.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            xsum_r <= 8'd0;
        end else if (start_load_s) begin
            xsum_r <= 8'd0;
        end else if (byte_in_s) begin
            xsum_r <= xor_accumulate(xsum_r, bus.rx_data);
        end else begin
            xsum_r <= xsum_r;
        end
    end
`endif

    // The CPU owns the read address only while running; otherwise the loader drives it.
    assign bus.mem_addr  = cpu_en_r ? bus.pc : load_addr_r;
    assign bus.mem_wdata = word_s;
    assign bus.mem_we    = mem_we_r;

    assign o_cpu_en     = cpu_en_r;
    assign o_load_done  = load_done_r;
    assign o_load_err   = load_err_r;
    assign o_word_count = word_count_r;

endmodule

// File: tb/tb_imem_load_controller.sv
// -----------------------------------------------------------------------------
// tb_imem_load_controller
// Randomised stimulus with a scoreboard of expected memory writes built from a
// byte-stream model; a negedge monitor pops and compares on every write strobe.
// -----------------------------------------------------------------------------
module tb_imem_load_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_req = 1'b0;
    logic        cpu_en;
    logic        load_done;
    logic        load_err;
    logic [31:0] word_count;

    int checks = 0;
    int errors = 0;

    imem_load_controller_if #(.NBITS(32)) bus ();

    imem_load_controller #(
        .NBITS     (32),
        .CELDAS    (60),
        .HALT_WORD (32'hFFFF_FFFF)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (rst_n),
        .i_load_req   (load_req),
        .bus          (bus),
        .o_cpu_en     (cpu_en),
        .o_load_done  (load_done),
        .o_load_err   (load_err),
        .o_word_count (word_count)
    );

    always #5 clk = ~clk;

    // Reference model of a load: byte stream -> expected (addr,data) writes.
    logic [63:0] exp_q[$];
    logic [31:0] m_addr;
    logic [31:0] m_acc;
    int          m_nbytes;
    int          m_words;
    bit          m_done;
    bit          m_err;
    logic [7:0]  m_xor;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_start();
        m_addr = 32'd0; m_acc = 32'd0; m_nbytes = 0; m_words = 0;
        m_done = 1'b0; m_err = 1'b0; m_xor = 8'd0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (!m_done) begin
            m_acc = {m_acc[23:0], b};
            m_xor = m_xor ^ b;
            m_nbytes++;
            if (m_nbytes % 4 == 0) begin
                exp_q.push_back({m_addr, m_acc});
                m_words++;
                if (m_acc == 32'hFFFF_FFFF || m_addr + 32'd4 >= 32'd60) m_done = 1'b1;
                else m_addr = m_addr + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic start_load();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
        model_start();
        check("start_cpu_en", 32'(cpu_en), 32'd0);
        check("start_done", 32'(load_done), 32'd0);
        check("start_err", 32'(load_err), 32'd0);
        check("start_wcount", word_count, 32'd0);
        check("start_addr", bus.mem_addr, 32'd0);
    endtask

    // Send one word MSB first with random gaps; optionally strobe a byte on the write cycle.
    task automatic send_word(input logic [31:0] w, input bit overrun);
        logic [7:0] b;
        for (int i = 0; i < 4; i++) begin
            b = w[31 - 8*i -: 8];
            model_byte(b);
            send_byte(b);
            if (i < 3) repeat ($urandom_range(0, 2)) tick();
        end
        check("we_latency", 32'(bus.mem_we), 32'd1);
        if (overrun) begin
            bus.rx_data  = 8'($urandom);
            bus.rx_valid = 1'b1;
            m_err = 1'b1;
        end
        tick();
        bus.rx_valid = 1'b0;
        check("we_single", 32'(bus.mem_we), 32'd0);
        check("word_count", word_count, 32'(m_words));
        if (overrun) check("overrun_err", 32'(load_err), 32'd1);
    endtask

    task automatic finish_program();
`ifdef IMEM_LOADER_CHECKSUM_EN
        check("check_cpu_en", 32'(cpu_en), 32'd0);
        send_byte(m_xor);
`endif
        for (int i = 0; i < 20 && cpu_en !== 1'b1; i++) tick();
        check("run_entered", 32'(cpu_en), 32'd1);
        check("run_done", 32'(load_done), 32'd1);
        check("run_wcount", word_count, 32'(m_words));
        check("run_err", 32'(load_err), 32'(m_err));
    endtask

    // Scoreboard monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin : monitor
        logic [63:0] e;
        if (bus.mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%h:%h expected=none", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", bus.mem_addr, e[63:32]);
                check("wr_data", bus.mem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        bus.rx_data = 8'd0; bus.rx_valid = 1'b0; bus.pc = 32'h10;
        model_start();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Reset state; IDLE drives the load address, not the PC.
        check("rst_cpu_en", 32'(cpu_en), 32'd0);
        check("rst_done", 32'(load_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);
        check("rst_wcount", word_count, 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", bus.mem_addr, 32'd0);
        send_byte(8'hAB);   // dropped in IDLE
        check("idle_drop_we", 32'(bus.mem_we), 32'd0);

        // Basic two-word program.
        start_load();
        send_word(32'h0000_0820, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        finish_program();
        check("run_pc_10", bus.mem_addr, 32'h10);
        bus.pc = 32'h24;
        #1;
        check("run_pc_24", bus.mem_addr, 32'h24);
        send_byte(8'h55);   // dropped in RUN
        check("run_drop_wcount", word_count, 32'd2);
        check("run_drop_err", 32'(load_err), 32'd0);

        // Reload from RUN, then fill capacity with non-halt words; stray load_req ignored.
        bus.pc = 32'h8;
        start_load();
        for (int k = 0; k < 15; k++) begin
            w = $urandom;
            if (w == 32'hFFFF_FFFF) w = 32'h0;
            if (k == 3) begin
                load_req = 1'b1;
                tick();
                load_req = 1'b0;
            end
            send_word(w, 1'b0);
        end
        finish_program();
        check("cap_wcount", word_count, 32'd15);

        // Overrun on a write cycle: byte dropped, error sticky, next word intact.
        start_load();
        send_word($urandom & 32'h7FFF_FFFF, 1'b1);
        send_word($urandom & 32'h7FFF_FFFF, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        finish_program();

        // Reset in the middle of a load.
        start_load();
        send_word($urandom & 32'h7FFF_FFFF, 1'b0);
        check("pre_rst_addr", bus.mem_addr, 32'd4);
        send_byte(8'h12);
        send_byte(8'h34);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_cpu_en", 32'(cpu_en), 32'd0);
        check("arst_wcount", word_count, 32'd0);
        check("arst_addr", bus.mem_addr, 32'd0);
        check("arst_wdata", bus.mem_wdata, 32'd0);
        check("arst_done", 32'(load_done), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        start_load();
        send_word(32'h0000_002A, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        finish_program();

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Wrong checksum parks in ERROR until a new load request.
        start_load();
        send_word(32'h0000_0820, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        check("xsum_model", 32'(m_xor), 32'h28);
        send_byte(8'h29);
        check("err_flag", 32'(load_err), 32'd1);
        check("err_cpu_en", 32'(cpu_en), 32'd0);
        check("err_done", 32'(load_done), 32'd0);
        send_byte(8'h28);
        repeat (3) tick();
        check("err_hold_cpu_en", 32'(cpu_en), 32'd0);
        check("err_hold_flag", 32'(load_err), 32'd1);
        start_load();
        send_word(32'h0000_0820, 1'b0);
        send_word(32'hFFFF_FFFF, 1'b0);
        finish_program();
`endif

        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
